// File: rtl/pipelined_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder_pkg
// Description : Shared helpers for the pipelined adder. This package provides
//               the slice-width derivation and the parameter legality
//               predicate that the top level uses to reject bad parameters
//               during elaboration.
// Revision    : 1.0 - initial release
// ============================================================================
package pipelined_adder_pkg;

    // Width of one slice. Only meaningful when params_legal() holds. The
    // zero guard only keeps elaboration from dividing by zero before the
    // legality check can report the real problem.
    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    // A parameter set is usable when every slice is at least one bit wide and
    // every slice has the same width.
    function automatic bit params_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_adder_add_slice.sv
`default_nettype none
// ============================================================================
// Module      : add_slice
// Description : Combinational CHUNK-bit adder slice, s/co = a + b + ci.
//               It also exposes the carry into its own MSB so that the slice
//               at the top of the word can form signed overflow.
// Ports       : a, b      - slice operands
//               ci        - carry in
//               s         - slice sum
//               co        - carry out of the slice MSB
//               c_msb_in  - carry into the slice MSB
// Revision    : 1.0 - initial release
// ============================================================================
module add_slice
    import pipelined_adder_pkg::*;
#(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    assign s      = w_full[CHUNK-1:0];
    assign co     = w_full[CHUNK];

    // Each sum bit is a ^ b ^ carry_in at that position. XOR-ing the sum MSB
    // with the operand MSBs therefore recovers the carry into the MSB without
    // a second adder.
    assign c_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ w_full[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder
// Description : This is a pipelined WIDTH-bit add/subtract unit with a
//               valid/ready stream interface. The operands are cut into
//               STAGES equal slices, and one slice is added per stage. The
//               carry is registered between stages. Operand slices are skewed
//               on the way in and sum slices are deskewed on the way out, so
//               that one full result leaves per cycle.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               in_valid/in_ready   - operand handshake
//               in1, in2, cin, sub  - operands; sub selects A + ~B + cin
//               out_valid/out_ready - result handshake
//               sum, cout, ovf      - result, carry out, signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_chunk = chunk_width(WIDTH, STAGES);

    generate
        if (!params_legal(WIDTH, STAGES)) begin : g_param_check
            $fatal(1, "pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
        end
    endgenerate

    logic              w_adv;
    logic [WIDTH-1:0]  w_b_in;
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] w_carry;

    // The whole pipe moves in lock-step. It only freezes when a finished
    // result is sitting at the output and is not being taken.
    assign w_adv     = ~r_valid[STAGES-1] | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_valid[STAGES-1];
    assign cout      = w_carry[STAGES-1];

    // Subtraction is addition of the one's complement. The caller supplies
    // the +1 through cin.
    assign w_b_in = sub ? ~in2 : in2;

    // Because in_ready equals w_adv, capturing in_valid on every advance is
    // the same as capturing the accept condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_adv) begin
            r_valid[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    generate
        for (genvar j = 0; j < STAGES; j++) begin : g_slice
            logic [c_chunk-1:0] w_a;
            logic [c_chunk-1:0] w_b;
            logic               w_ci;
            logic [c_chunk-1:0] w_s;
            logic               w_co;
            logic               w_c_msb_in;
            logic               r_co;
            // Slice j is computed in stage j. It must then ride STAGES-j
            // registers so that it reaches the output together with the top
            // slice.
            logic [c_chunk-1:0] r_s [STAGES-j];

            if (j == 0) begin : g_head
                assign w_a  = in1[c_chunk-1:0];
                assign w_b  = w_b_in[c_chunk-1:0];
                assign w_ci = cin;
            end else begin : g_skew
                // Operand slice j waits j cycles, which matches the arrival
                // of the registered carry from slice j-1.
                logic [c_chunk-1:0] r_a [j];
                logic [c_chunk-1:0] r_b [j];

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int i = 0; i < j; i++) begin
                            r_a[i] <= '0;
                            r_b[i] <= '0;
                        end
                    end else if (w_adv) begin
                        r_a[0] <= in1[j*c_chunk +: c_chunk];
                        r_b[0] <= w_b_in[j*c_chunk +: c_chunk];
                        for (int i = 1; i < j; i++) begin
                            r_a[i] <= r_a[i-1];
                            r_b[i] <= r_b[i-1];
                        end
                    end
                end

                assign w_a  = r_a[j-1];
                assign w_b  = r_b[j-1];
                assign w_ci = w_carry[j-1];
            end

            add_slice #(
                .CHUNK    (c_chunk)
            ) u_add_slice (
                .a        (w_a),
                .b        (w_b),
                .ci       (w_ci),
                .s        (w_s),
                .co       (w_co),
                .c_msb_in (w_c_msb_in)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_co <= 1'b0;
                    for (int i = 0; i < STAGES - j; i++) begin
                        r_s[i] <= '0;
                    end
                end else if (w_adv) begin
                    r_co   <= w_co;
                    r_s[0] <= w_s;
                    for (int i = 1; i < STAGES - j; i++) begin
                        r_s[i] <= r_s[i-1];
                    end
                end
            end

            assign w_carry[j]                  = r_co;
            assign sum[j*c_chunk +: c_chunk]   = r_s[STAGES-j-1];

            if (j == STAGES - 1) begin : g_top
                // The top slice is computed in the last stage, so its
                // overflow is registered alongside the final carry.
                logic r_ovf;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_ovf <= 1'b0;
                    end else if (w_adv) begin
                        r_ovf <= w_c_msb_in ^ w_co;
                    end
                end

                assign ovf = r_ovf;
            end else begin : g_low
                // Lower slices have no use for the carry into their MSB.
                logic w_unused_c_msb;
                assign w_unused_c_msb = w_c_msb_in;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_adder
// Description : Self-checking bench for pipelined_adder. This bench runs
//               directed tests on the default 64/4 configuration. It then
//               runs a random valid/ready sweep on four other parameter sets
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

    localparam int W     = 64;
    localparam int S     = 4;
    localparam int NBEAT = 10000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic         cin, sub, cout, ovf;
    logic [W-1:0] in1, in2, sum;

    int n_total = 0;
    int n_bad   = 0;

    bit sweep_on   = 1'b0;
    bit sweep_stop = 1'b0;

    always #5 clk = ~clk;

    pipelined_adder #(
        .WIDTH     (W),
        .STAGES    (S)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The caller has just driven a beat after a falling edge. This task waits
    // for out_valid and checks how many cycles that took.
    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n++;
        end while (out_valid !== 1'b1 && n < 50);
        check(tag, n, exp_lat);
    endtask

    function automatic int sw_w(input int i);
        case (i)
            0:       return 8;
            1:       return 8;
            2:       return 32;
            default: return 64;
        endcase
    endfunction

    function automatic int sw_s(input int i);
        case (i)
            0:       return 1;
            1:       return 8;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    generate
        for (genvar g = 0; g < 4; g++) begin : g_sweep
            localparam int SW = sw_w(g);
            localparam int SS = sw_s(g);

            logic          iv, ir, ov, ordy, ci, sb, co, of;
            logic [SW-1:0] a, b, s;
            bit            done;

            pipelined_adder #(
                .WIDTH     (SW),
                .STAGES    (SS)
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (iv),
                .in_ready  (ir),
                .in1       (a),
                .in2       (b),
                .cin       (ci),
                .sub       (sb),
                .out_valid (ov),
                .out_ready (ordy),
                .sum       (s),
                .cout      (co),
                .ovf       (of)
            );

            // This model returns {ovf, cout, sum}. Overflow is taken from
            // the operand and result signs.
            function automatic logic [SW+1:0] model(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                                    input logic c, input logic m);
                logic [SW-1:0] yb;
                logic [SW:0]   full;
                logic          v;
                yb   = m ? ~y : y;
                full = {1'b0, x} + {1'b0, yb} + {{SW{1'b0}}, c};
                v    = (x[SW-1] == yb[SW-1]) && (full[SW-1] != x[SW-1]);
                return {v, full};
            endfunction

            initial begin
                logic [SW+1:0] q[$];
                logic [SW+1:0] exp;
                logic [63:0]   r;
                int            sent;
                int            got;
                sent = 0;
                got  = 0;
                iv   = 1'b0;
                ordy = 1'b0;
                a    = '0;
                b    = '0;
                ci   = 1'b0;
                sb   = 1'b0;
                done = 1'b0;
                wait (sweep_on);
                while (got < NBEAT && !sweep_stop) begin
                    @(negedge clk);
                    r    = {$urandom(), $urandom()};
                    a    = r[SW-1:0];
                    r    = {$urandom(), $urandom()};
                    b    = r[SW-1:0];
                    ci   = 1'($urandom_range(0, 1));
                    sb   = 1'($urandom_range(0, 1));
                    iv   = (sent < NBEAT) && ($urandom_range(0, 3) != 0);
                    ordy = ($urandom_range(0, 3) != 0);
                    #1;
                    if (iv && ir) begin
                        q.push_back(model(a, b, ci, sb));
                        sent++;
                    end
                    if (ov && ordy) begin
                        n_total++;
                        if (q.size() == 0) begin
                            n_bad++;
                            $error("FAIL sweep%0d_spurious: observed=%0h expected=no_result", g, {of, co, s});
                        end else begin
                            exp = q.pop_front();
                            assert ({of, co, s} === exp) else begin
                                n_bad++;
                                $error("FAIL sweep%0d_result: observed=%0h expected=%0h", g, {of, co, s}, exp);
                            end
                        end
                        got++;
                    end
                end
                iv = 1'b0;
                n_total++;
                assert (q.size() == 0 && got == NBEAT) else begin
                    n_bad++;
                    $error("FAIL sweep%0d_drain: observed=%0d/%0d left expected=%0d/0", g, got, q.size(), NBEAT);
                end
                done = 1'b1;
            end
        end
    endgenerate

    initial begin
        int  sent, got, cyc, stray;
        bit  exp_v;
        bit  all_done;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in1       = '0;
        in2       = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        #1 rst_n  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // All-ones plus carry wraps to zero with a carry out
        @(negedge clk);
        in_valid = 1'b1; in1 = '1; in2 = '0; cin = 1'b1; sub = 1'b0;
        wait_valid("t1_latency", 4);
        check("t1_sum", sum, 0);
        check("t1_cout", cout, 1);
        check("t1_ovf", ovf, 0);

        // Signed overflow on add
        @(negedge clk);
        in_valid = 1'b1; in1 = 64'h7FFF_FFFF_FFFF_FFFF; in2 = 64'd1; cin = 1'b0; sub = 1'b0;
        wait_valid("t2a_latency", 4);
        check("t2a_sum", sum, 64'h8000_0000_0000_0000);
        check("t2a_cout", cout, 0);
        check("t2a_ovf", ovf, 1);

        // Same operands subtracted
        @(negedge clk);
        in_valid = 1'b1; in1 = 64'h7FFF_FFFF_FFFF_FFFF; in2 = 64'd1; cin = 1'b1; sub = 1'b1;
        wait_valid("t2b_latency", 4);
        check("t2b_sum", sum, 64'h7FFF_FFFF_FFFF_FFFE);
        check("t2b_cout", cout, 1);
        check("t2b_ovf", ovf, 0);

        // Back-to-back beats at full rate
        cin = 1'b0; sub = 1'b0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (k < 8) begin
                in_valid = 1'b1; in1 = 64'(k); in2 = 64'(3 * k);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            exp_v = (k >= 4) && (k < 12);
            check("t3_in_ready", in_ready, 1);
            check("t3_out_valid", out_valid, exp_v);
            if (exp_v) check("t3_sum", sum, 4 * (k - 4));
        end

        // Backpressure while the pipe is full
        sent = 0; got = 0; cyc = 0;
        while (got < 10 && cyc < 60) begin
            @(negedge clk);
            in_valid  = (sent < 10);
            in1       = 64'(100 + sent);
            in2       = 64'(sent);
            out_ready = !(cyc >= 6 && cyc <= 8);
            #1;
            if (!out_ready) begin
                check("t4_stall_valid", out_valid, 1);
                check("t4_stall_in_ready", in_ready, 0);
                check("t4_stall_sum", sum, 100 + 2 * got);
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                check("t4_sum", sum, 100 + 2 * got);
                got++;
            end
            cyc++;
        end
        check("t4_count", got, 10);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset with beats in flight
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = (k < 3);
            in1 = 64'(k + 10); in2 = '0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("t5_valid_pre_reset", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t5_valid_in_reset", out_valid, 0);
        check("t5_sum_in_reset", sum, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (out_valid !== 1'b0) stray++;
        end
        check("t5_no_stale", stray, 0);
        @(negedge clk);
        in_valid = 1'b1; in1 = 64'h1234; in2 = 64'h1111; cin = 1'b0; sub = 1'b0;
        wait_valid("t5_latency", 4);
        check("t5_sum", sum, 64'h2345);

        // Random sweep across parameter sets
        sweep_on = 1'b1;
        cyc      = 0;
        all_done = 1'b0;
        while (!all_done && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            all_done = g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done;
        end
        check("sweep_finished", all_done, 1);
        sweep_stop = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
